linreg_engine: RTL and testbench

LINREG_ENGINE -- requirements
Module: linreg_engine

---
 rtl/linreg_pkg.sv | 32 +++
 rtl/linreg_divider.sv | 76 +++++++
 rtl/linreg_engine.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_linreg_engine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/linreg_pkg.sv
// Shared types and width helpers for the linear-regression engine.
// Latency: n/a (package only).
// Backpressure: n/a.
package linreg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MEAN,
    S_PASS2,
    S_DIV,
    S_INTERCEPT,
    S_EMIT
  } state_t;

  // Residual width: wide enough for any y minus fit over the sample range.
  function automatic int calc_err_w(input int data_w);
    return 2 * data_w;
  endfunction

  // Signed fixed-point coefficient width: integer part, fraction, sign and headroom.
  function automatic int calc_coef_w(input int data_w, input int frac_w);
    return data_w + frac_w + 2;
  endfunction

  // Accumulator width: product of two (data_w+1)-bit signed deviations, summed
  // 2^log2_n times, plus a guard bit so the sum never wraps.
  function automatic int calc_acc_w(input int data_w, input int log2_n);
    return 2 * (data_w + 1) + log2_n + 1;
  endfunction

endpackage

// File: rtl/linreg_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; quotient truncates.
// Latency: NUM_W cycles from accepted start to the one-cycle done pulse.
// Backpressure: start is ignored while busy; the quotient is held until the next start.
//
// Ports: clk, rst (async active-low), i_start, i_num[NUM_W], i_den[DEN_W],
//        o_busy, o_done, o_quo[NUM_W].
module linreg_divider #(
  parameter int NUM_W = 35,
  parameter int DEN_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_busy,
  output logic             o_done,
  output logic [NUM_W-1:0] o_quo
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic             r_busy;
  logic             r_done;
  logic [NUM_W-1:0] r_quo;
  logic [DEN_W-1:0] r_rem;
  logic [DEN_W-1:0] r_den;
  logic [CNT_W-1:0] r_cnt;

  // Shift the next dividend bit into the partial remainder. The remainder is
  // always below the divisor, so one extra bit is enough for the compare.
  logic [DEN_W:0]   w_rem_sh;
  logic             w_ge;
  logic [DEN_W-1:0] w_diff;

  assign w_rem_sh = {r_rem, r_quo[NUM_W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_den});
  // The true difference is below the divisor, so the low bits are exact.
  assign w_diff   = w_rem_sh[DEN_W-1:0] - r_den;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_busy <= 1'b1;
          r_quo  <= i_num;
          r_rem  <= '0;
          r_den  <= i_den;
          r_cnt  <= CNT_W'(NUM_W);
        end
      end else begin
        // Dividend bits leave the top of r_quo while quotient bits enter the bottom.
        r_rem <= w_ge ? w_diff : w_rem_sh[DEN_W-1:0];
        r_quo <= {r_quo[NUM_W-2:0], w_ge};
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quo  = r_quo;

endmodule

// File: rtl/linreg_engine.sv
// Batch least-squares fit y = b0 + b1*x over 2^LOG2_N samples, then streams residuals.
// Latency: N-th accept to coef_done = MEAN + N PASS2 cycles + DIV (setup + NUM_W) + INTERCEPT.
// Backpressure: in_ready only in LOAD; out_valid/out_err hold while out_ready is low.
//
// Ports: clk, rst (async active-low), in_valid/in_ready/in_x/in_y (sample input),
//        b0/b1 (signed Q.FRAC_W coefficients), coef_done (pulse), degenerate,
//        out_valid/out_ready/out_err (signed residual stream, load order).
module linreg_engine
  import linreg_pkg::*;
#(
  parameter int  DATA_W = 10,
  parameter int  LOG2_N = 4,
  parameter int  FRAC_W = 8,
  localparam int ERR_W  = calc_err_w(DATA_W),
  localparam int COEF_W = calc_coef_w(DATA_W, FRAC_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic        [DATA_W-1:0] in_x,
  input  logic        [DATA_W-1:0] in_y,
  output logic signed [COEF_W-1:0] b0,
  output logic signed [COEF_W-1:0] b1,
  output logic                     coef_done,
  output logic                     degenerate,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ERR_W-1:0]  out_err
);

  localparam int N     = 1 << LOG2_N;
  localparam int IDX_W = LOG2_N;
  localparam int SUM_W = DATA_W + LOG2_N;
  localparam int ACC_W = calc_acc_w(DATA_W, LOG2_N);
  localparam int NUM_W = ACC_W + FRAC_W;
  localparam int EXT_W = COEF_W + DATA_W + 4;

  localparam logic signed [COEF_W-1:0] COEF_MAX = {1'b0, {(COEF_W-1){1'b1}}};
  localparam logic signed [COEF_W-1:0] COEF_MIN = {1'b1, {(COEF_W-1){1'b0}}};
  localparam logic signed [ERR_W-1:0]  ERR_MAX  = {1'b0, {(ERR_W-1){1'b1}}};
  localparam logic signed [ERR_W-1:0]  ERR_MIN  = {1'b1, {(ERR_W-1){1'b0}}};
  // Smallest quotient magnitude that no longer fits a positive coefficient.
  localparam logic [NUM_W-1:0] QLIM = {{(NUM_W-COEF_W){1'b0}}, 1'b1, {(COEF_W-1){1'b0}}};

  state_t                    r_state;
  logic        [DATA_W-1:0]  r_buf_x [N];
  logic        [DATA_W-1:0]  r_buf_y [N];
  logic        [IDX_W-1:0]   r_wr_idx;
  logic        [IDX_W-1:0]   r_rd_idx;
  logic        [SUM_W-1:0]   r_sum_x;
  logic        [SUM_W-1:0]   r_sum_y;
  logic        [DATA_W-1:0]  r_mx;
  logic        [DATA_W-1:0]  r_my;
  logic signed [ACC_W-1:0]   r_sxx;
  logic signed [ACC_W-1:0]   r_sxy;
  logic                      r_div_go;
  logic                      r_div_start;
  logic                      r_div_neg;
  logic signed [COEF_W-1:0]  r_b1_q;
  logic signed [COEF_W-1:0]  r_b0;
  logic signed [COEF_W-1:0]  r_b1;
  logic                      r_degen;
  logic                      r_coef_done;
  logic                      r_out_vld;
  logic signed [ERR_W-1:0]   r_out_err;

  logic                      w_accept;
  logic        [DATA_W-1:0]  w_rd_x;
  logic        [DATA_W-1:0]  w_rd_y;
  logic signed [DATA_W:0]    w_dx;
  logic signed [DATA_W:0]    w_dy;
  logic signed [ACC_W-1:0]   w_dxe;
  logic signed [ACC_W-1:0]   w_dye;
  logic signed [ACC_W-1:0]   w_pxx;
  logic signed [ACC_W-1:0]   w_pxy;
  logic        [ACC_W-1:0]   w_sxy_mag;
  logic        [NUM_W-1:0]   w_div_num;
  logic        [ACC_W-1:0]   w_div_den;
  logic                      w_div_busy;
  logic                      w_div_done;
  logic        [NUM_W-1:0]   w_quo;
  logic signed [COEF_W-1:0]  w_b1_sat;
  logic signed [EXT_W-1:0]   w_xe;
  logic signed [EXT_W-1:0]   w_ye_sh;
  logic signed [EXT_W-1:0]   w_mxe;
  logic signed [EXT_W-1:0]   w_my_sh;
  logic signed [EXT_W-1:0]   w_b0e;
  logic signed [EXT_W-1:0]   w_b1e;
  logic signed [EXT_W-1:0]   w_b1qe;
  logic signed [EXT_W-1:0]   w_b0_wide;
  logic                      w_b0_fit;
  logic signed [COEF_W-1:0]  w_b0_sat;
  logic signed [EXT_W-1:0]   w_fit;
  logic signed [EXT_W-1:0]   w_err_sh;
  logic                      w_err_fit;
  logic signed [ERR_W-1:0]   w_err_sat;

  assign in_ready = (r_state == S_LOAD);
  assign w_accept = in_valid & in_ready;

  // Sample buffer carries no reset; it is always rewritten before it is read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_x[r_wr_idx] <= in_x;
      r_buf_y[r_wr_idx] <= in_y;
    end
  end

  assign w_rd_x = r_buf_x[r_rd_idx];
  assign w_rd_y = r_buf_y[r_rd_idx];

  // Second pass: deviations from the floored means, exact signed products.
  assign w_dx  = $signed({1'b0, w_rd_x}) - $signed({1'b0, r_mx});
  assign w_dy  = $signed({1'b0, w_rd_y}) - $signed({1'b0, r_my});
  assign w_dxe = {{(ACC_W-DATA_W-1){w_dx[DATA_W]}}, w_dx};
  assign w_dye = {{(ACC_W-DATA_W-1){w_dy[DATA_W]}}, w_dy};
  assign w_pxx = w_dxe * w_dxe;
  assign w_pxy = w_dxe * w_dye;

  // Divide magnitudes; the sign of sxy is reapplied to the quotient.
  assign w_sxy_mag = r_sxy[ACC_W-1] ? ACC_W'(-r_sxy) : ACC_W'(r_sxy);
  assign w_div_num = {w_sxy_mag, {FRAC_W{1'b0}}};
  assign w_div_den = ACC_W'(r_sxx);

  linreg_divider #(
    .NUM_W (NUM_W),
    .DEN_W (ACC_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_div_start),
    .i_num   (w_div_num),
    .i_den   (w_div_den),
    .o_busy  (w_div_busy),
    .o_done  (w_div_done),
    .o_quo   (w_quo)
  );

  always_comb begin
    w_b1_sat = '0;
    if (r_div_neg) begin
      if (w_quo >= QLIM) w_b1_sat = COEF_MIN;
      else               w_b1_sat = -$signed(w_quo[COEF_W-1:0]);
    end else begin
      if (w_quo >= QLIM) w_b1_sat = COEF_MAX;
      else               w_b1_sat = $signed(w_quo[COEF_W-1:0]);
    end
  end

  // Fixed-point operands widened so neither intercept nor residual can wrap.
  assign w_xe    = {{(EXT_W-DATA_W){1'b0}}, w_rd_x};
  assign w_ye_sh = {{(EXT_W-DATA_W-FRAC_W){1'b0}}, w_rd_y, {FRAC_W{1'b0}}};
  assign w_mxe   = {{(EXT_W-DATA_W){1'b0}}, r_mx};
  assign w_my_sh = {{(EXT_W-DATA_W-FRAC_W){1'b0}}, r_my, {FRAC_W{1'b0}}};
  assign w_b0e   = {{(EXT_W-COEF_W){r_b0[COEF_W-1]}}, r_b0};
  assign w_b1e   = {{(EXT_W-COEF_W){r_b1[COEF_W-1]}}, r_b1};
  assign w_b1qe  = {{(EXT_W-COEF_W){r_b1_q[COEF_W-1]}}, r_b1_q};

  // Intercept: value fits when all bits above the coefficient sign agree.
  assign w_b0_wide = w_my_sh - w_b1qe * w_mxe;
  assign w_b0_fit  = (&w_b0_wide[EXT_W-1:COEF_W-1]) | ~(|w_b0_wide[EXT_W-1:COEF_W-1]);
  assign w_b0_sat  = w_b0_fit ? w_b0_wide[COEF_W-1:0]
                              : (w_b0_wide[EXT_W-1] ? COEF_MIN : COEF_MAX);

  // Residual in Q.FRAC_W, floored back to an integer by the arithmetic shift.
  assign w_fit     = w_ye_sh - (w_b0e + w_b1e * w_xe);
  assign w_err_sh  = w_fit >>> FRAC_W;
  assign w_err_fit = (&w_err_sh[EXT_W-1:ERR_W-1]) | ~(|w_err_sh[EXT_W-1:ERR_W-1]);
  assign w_err_sat = w_err_fit ? w_err_sh[ERR_W-1:0]
                               : (w_err_sh[EXT_W-1] ? ERR_MIN : ERR_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_sum_x     <= '0;
      r_sum_y     <= '0;
      r_mx        <= '0;
      r_my        <= '0;
      r_sxx       <= '0;
      r_sxy       <= '0;
      r_div_go    <= 1'b0;
      r_div_start <= 1'b0;
      r_div_neg   <= 1'b0;
      r_b1_q      <= '0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_degen     <= 1'b0;
      r_coef_done <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_err   <= '0;
    end else begin
      r_div_start <= 1'b0;
      r_coef_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wr_idx <= '0;
          r_sum_x  <= '0;
          r_sum_y  <= '0;
          r_state  <= S_LOAD;
        end
        S_LOAD: begin
          if (w_accept) begin
            r_sum_x  <= r_sum_x + {{LOG2_N{1'b0}}, in_x};
            r_sum_y  <= r_sum_y + {{LOG2_N{1'b0}}, in_y};
            r_wr_idx <= r_wr_idx + IDX_W'(1);
            if (r_wr_idx == IDX_W'(N - 1)) r_state <= S_MEAN;
          end
        end
        S_MEAN: begin
          r_mx     <= DATA_W'(r_sum_x >> LOG2_N);
          r_my     <= DATA_W'(r_sum_y >> LOG2_N);
          r_sxx    <= '0;
          r_sxy    <= '0;
          r_rd_idx <= '0;
          r_state  <= S_PASS2;
        end
        S_PASS2: begin
          r_sxx    <= r_sxx + w_pxx;
          r_sxy    <= r_sxy + w_pxy;
          r_rd_idx <= r_rd_idx + IDX_W'(1);
          if (r_rd_idx == IDX_W'(N - 1)) begin
            r_div_go <= 1'b0;
            r_state  <= S_DIV;
          end
        end
        S_DIV: begin
          if (!r_div_go) begin
            if (!w_div_busy) begin
              r_div_go <= 1'b1;
              if (r_sxx == '0) begin
                // All x equal: slope undefined, report flat line through my.
                r_b1_q  <= '0;
                r_degen <= 1'b1;
                r_state <= S_INTERCEPT;
              end else begin
                r_div_start <= 1'b1;
                r_div_neg   <= r_sxy[ACC_W-1];
                r_degen     <= 1'b0;
              end
            end
          end else if (w_div_done) begin
            r_b1_q  <= w_b1_sat;
            r_state <= S_INTERCEPT;
          end
        end
        S_INTERCEPT: begin
          r_b1        <= r_b1_q;
          r_b0        <= w_b0_sat;
          r_coef_done <= 1'b1;
          r_rd_idx    <= '0;
          r_out_vld   <= 1'b0;
          r_state     <= S_EMIT;
        end
        S_EMIT: begin
          // Load one residual, hold it until taken, then move to the next entry.
          if (!r_out_vld) begin
            r_out_err <= w_err_sat;
            r_out_vld <= 1'b1;
          end else if (out_ready) begin
            r_out_vld <= 1'b0;
            if (r_rd_idx == IDX_W'(N - 1)) r_state <= S_IDLE;
            else                           r_rd_idx <= r_rd_idx + IDX_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign b0         = r_b0;
  assign b1         = r_b1;
  assign coef_done  = r_coef_done;
  assign degenerate = r_degen;
  assign out_valid  = r_out_vld;
  assign out_err    = r_out_err;

endmodule

// File: tb/tb_linreg_engine.sv
// Directed bench for linreg_engine: fits, degenerate batch, outlier, stalls, reset, gaps.
// Latency: bounded waits on coef_done and residual transfers.
// Backpressure: out_ready held high or toggled randomly during residual streaming.
module tb_linreg_engine;

  localparam int DATA_W = 10;
  localparam int LOG2_N = 4;
  localparam int FRAC_W = 8;
  localparam int N      = 16;
  localparam int ERR_W  = 20;
  localparam int COEF_W = 20;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic        [DATA_W-1:0] in_x;
  logic        [DATA_W-1:0] in_y;
  logic signed [COEF_W-1:0] b0;
  logic signed [COEF_W-1:0] b1;
  logic                     coef_done;
  logic                     degenerate;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ERR_W-1:0]  out_err;

  always #5 clk = ~clk;

  linreg_engine #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N),
    .FRAC_W (FRAC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .b0         (b0),
    .b1         (b1),
    .coef_done  (coef_done),
    .degenerate (degenerate),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_err    (out_err)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  int     vx [N];
  int     vy [N];
  longint got_err [N];
  longint got_sum;
  int     done_cnt = 0;
  int     rdy_viol = 0;
  int     vld_viol = 0;
  bit     mon_rdy  = 1'b0;
  bit     mon_vld  = 1'b0;

  always @(negedge clk) begin
    if (coef_done === 1'b1) done_cnt++;
    if (mon_rdy && in_ready !== 1'b0) rdy_viol++;
    if (mon_vld && out_valid !== 1'b0) vld_viol++;
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference residual: floor((y*2^F - (b0 + b1*x)) / 2^F).
  function automatic longint model_err(input int x, input int y, input int eb0, input int eb1);
    longint d;
    d = longint'(y) * 256 - (longint'(eb0) + longint'(eb1) * longint'(x));
    return d >>> FRAC_W;
  endfunction

  task automatic check_reset_state(input string pfx);
    check({pfx, "_b0"}, b0, 0);
    check({pfx, "_b1"}, b1, 0);
    check({pfx, "_degen"}, degenerate, 0);
    check({pfx, "_coef_done"}, coef_done, 0);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_out_err"}, out_err, 0);
    check({pfx, "_in_ready"}, in_ready, 0);
  endtask

  task automatic set_line(input bit bump);
    for (int i = 0; i < N; i++) begin
      vx[i] = 2 * i;
      vy[i] = 2 * vx[i] + 3;
    end
    if (bump) vy[3] = vy[3] + 40;
  endtask

  task automatic load_batch(input bit gaps, input bit garbage);
    int t;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_x     = DATA_W'(vx[i]);
      in_y     = DATA_W'(vy[i]);
      t = 0;
      while (in_ready !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) check("load_ready_timeout", in_ready, 1);
    end
    @(negedge clk);
    if (garbage) begin
      in_valid = 1'b1;
      in_x     = DATA_W'($urandom_range(0, 1023));
      in_y     = DATA_W'($urandom_range(0, 1023));
      mon_rdy  = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_coef();
    int t = 0;
    while (coef_done !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("coef_done_seen", coef_done, 1);
  endtask

  task automatic collect(input bit rnd, input int eb0, input int eb1);
    int got = 0;
    int cyc = 0;
    bit have = 1'b0;
    logic signed [ERR_W-1:0] held = '0;
    got_sum = 0;
    while (got < N && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (have) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_err_hold", out_err, held);
      end else if (out_valid === 1'b1) begin
        held = out_err;
        have = 1'b1;
        got_err[got] = out_err;
        got_sum += out_err;
        check($sformatf("err%0d", got), out_err, model_err(vx[got], vy[got], eb0, eb1));
      end
      if (have) begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          got++;
          have = 1'b0;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    check("xfer_count", got, N);
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("no_extra_valid", out_valid, 0);
  endtask

  initial begin
    int     d0;
    int     imax;
    longint exp_sum;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst = 1'b1;

    // Exact line y = 2x + 3 over x = 0..30.
    set_line(1'b0);
    load_batch(1'b0, 1'b0);
    wait_coef();
    check("line_b1", b1, 512);
    check("line_b0", b0, 768);
    check("line_degen", degenerate, 0);
    collect(1'b0, 768, 512);

    // Constant x: slope undefined, intercept is the floored mean of y.
    for (int i = 0; i < N; i++) begin
      vx[i] = 5;
      vy[i] = i;
    end
    d0 = done_cnt;
    load_batch(1'b0, 1'b0);
    wait_coef();
    check("degen_flag", degenerate, 1);
    check("degen_b1", b1, 0);
    check("degen_b0", b0, 1792);
    collect(1'b0, 1792, 0);
    check("degen_done_pulses", done_cnt - d0, 1);
    check("degen_flag_held", degenerate, 1);

    // Outlier on entry 3 with random output stalls.
    set_line(1'b1);
    load_batch(1'b0, 1'b0);
    wait_coef();
    check("outlier_b1", b1, 444);
    check("outlier_b0", b0, 2300);
    check("outlier_degen", degenerate, 0);
    collect(1'b1, 2300, 444);
    exp_sum = 0;
    for (int i = 0; i < N; i++) exp_sum += model_err(vx[i], vy[i], 2300, 444);
    check("outlier_err_sum", got_sum, exp_sum);
    imax = 0;
    for (int i = 1; i < N; i++) if (got_err[i] > got_err[imax]) imax = i;
    check("outlier_max_index", imax, 3);
    check("outlier_e3_positive", got_err[3] > 0, 1);

    // Reset in the middle of the second pass, then a clean batch.
    set_line(1'b0);
    load_batch(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b1;
    mon_vld = 1'b1;
    load_batch(1'b0, 1'b0);
    wait_coef();
    mon_vld = 1'b0;
    check("midrst_no_early_valid", vld_viol, 0);
    check("midrst_b1", b1, 512);
    check("midrst_b0", b0, 768);
    check("midrst_degen", degenerate, 0);
    collect(1'b0, 768, 512);

    // Input gaps during LOAD, in_valid held with junk while computing.
    load_batch(1'b1, 1'b1);
    wait_coef();
    in_valid = 1'b0;
    mon_rdy  = 1'b0;
    check("gaps_ready_outside_load", rdy_viol, 0);
    check("gaps_b1", b1, 512);
    check("gaps_b0", b0, 768);
    collect(1'b1, 768, 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
